// File: rtl/rat_pkg.sv
// ---------------------------------------------------------------------------
// rat_pkg
// Shared types and constants for the return-address stack slice.
//   pc_src_t         : DIN source encoding used on PC_MUX_SEL
//   PC_AW            : program counter address width
//   INTR_VEC_DEFAULT : default interrupt vector driven on DIN
// ---------------------------------------------------------------------------
package rat_pkg;

  localparam int PC_AW = 10;
  localparam logic [PC_AW-1:0] INTR_VEC_DEFAULT = 10'h3FF;

  typedef enum logic [1:0] {
    PC_SRC_IR    = 2'd0,
    PC_SRC_STACK = 2'd1,
    PC_SRC_INTR  = 2'd2,
    PC_SRC_RSVD  = 2'd3
  } pc_src_t;

endpackage : rat_pkg

// File: rtl/ret_addr_stack_if.sv
// ---------------------------------------------------------------------------
// ret_addr_stack_if
// Bus between the control unit / program counter and the return-address
// stack.
//   master : control side, drives PC_COUNT, IR_ADDR, PC_MUX_SEL, PUSH, POP, CLR
//   slave  : stack side, drives DIN, TOP, EMPTY, FULL, LEVEL, OVF, UNF
// ---------------------------------------------------------------------------
interface ret_addr_stack_if #(
  parameter int AW    = 10,
  parameter int DEPTH = 16
);

  localparam int LW = $clog2(DEPTH) + 1;

  logic [AW-1:0] PC_COUNT;
  logic [AW-1:0] IR_ADDR;
  logic [1:0]    PC_MUX_SEL;
  logic          PUSH;
  logic          POP;
  logic          CLR;
  logic [AW-1:0] DIN;
  logic [AW-1:0] TOP;
  logic          EMPTY;
  logic          FULL;
  logic [LW-1:0] LEVEL;
  logic          OVF;
  logic          UNF;

  modport master (
    output PC_COUNT, IR_ADDR, PC_MUX_SEL, PUSH, POP, CLR,
    input  DIN, TOP, EMPTY, FULL, LEVEL, OVF, UNF
  );

  modport slave (
    input  PC_COUNT, IR_ADDR, PC_MUX_SEL, PUSH, POP, CLR,
    output DIN, TOP, EMPTY, FULL, LEVEL, OVF, UNF
  );

endinterface : ret_addr_stack_if

// File: rtl/lifo_mem.sv
// ---------------------------------------------------------------------------
// lifo_mem
// DEPTH x AW register array, one synchronous write port and one
// asynchronous read port. Contents are intentionally not reset.
//   i_clk   : clock
//   i_we    : write enable
//   i_waddr : write index
//   i_wdata : write data
//   i_raddr : read index
//   o_rdata : read data (combinational)
// ---------------------------------------------------------------------------
module lifo_mem #(
  parameter  int AW    = 10,
  parameter  int DEPTH = 16,
  localparam int IW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [IW-1:0] i_waddr,
  input  logic [AW-1:0] i_wdata,
  input  logic [IW-1:0] i_raddr,
  output logic [AW-1:0] o_rdata
);

  logic [AW-1:0] r_mem [DEPTH];

  // Storage write port
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule : lifo_mem

// File: rtl/ret_addr_stack.sv
// ---------------------------------------------------------------------------
// ret_addr_stack
// Return-address stack and PC-source selector feeding the program counter
// load value.
//   CLK, RST_N : clock, asynchronous active-low reset
//   bus.slave  : PC_COUNT/IR_ADDR/PC_MUX_SEL/PUSH/POP/CLR in,
//                DIN/TOP/EMPTY/FULL/LEVEL/OVF/UNF out
// DIN and TOP are combinational from the current (pre-update) state so a
// pop-and-load hands the old top to the PC on the same edge LEVEL drops.
// ---------------------------------------------------------------------------
module ret_addr_stack
  import rat_pkg::*;
#(
  parameter int            AW       = PC_AW,
  parameter int            DEPTH    = 16,
  parameter logic [AW-1:0] INTR_VEC = INTR_VEC_DEFAULT
) (
  input  logic             CLK,
  input  logic             RST_N,
  ret_addr_stack_if.slave  bus
);

  localparam int IW = $clog2(DEPTH);
  localparam int LW = IW + 1;

  logic [LW-1:0] r_level;
  logic          r_ovf;
  logic          r_unf;

  logic [LW-1:0] w_level_dec;
  logic [LW-1:0] w_level_inc;
  logic          w_empty;
  logic          w_full;
  logic [AW-1:0] w_rd_data;
  logic [AW-1:0] w_top;
  logic [LW-1:0] w_level_nxt;
  logic          w_ovf_nxt;
  logic          w_unf_nxt;
  logic          w_we;
  logic [IW-1:0] w_waddr;
  pc_src_t       w_sel;

  assign w_level_dec = r_level - LW'(1);
  assign w_level_inc = r_level + LW'(1);
  assign w_empty     = (r_level == LW'(0));
  assign w_full      = (r_level == LW'(DEPTH));
  assign w_sel       = pc_src_t'(bus.PC_MUX_SEL);

  // Index wraps to all-ones when empty; the read is masked in that case.
  lifo_mem #(
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_mem (
    .i_clk   (CLK),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (bus.PC_COUNT),
    .i_raddr (w_level_dec[IW-1:0]),
    .o_rdata (w_rd_data)
  );

  // Top-of-stack view, zero when empty
  always_comb begin
    if (w_empty) begin
      w_top = '0;
    end else begin
      w_top = w_rd_data;
    end
  end

  // Program counter load source select
  always_comb begin
    case (w_sel)
      PC_SRC_IR:    bus.DIN = bus.IR_ADDR;
      PC_SRC_STACK: bus.DIN = w_top;
      PC_SRC_INTR:  bus.DIN = INTR_VEC;
      default:      bus.DIN = '0;
    endcase
  end

  // Next stack level, write strobe and sticky error flags
  always_comb begin
    w_level_nxt = r_level;
    w_ovf_nxt   = r_ovf;
    w_unf_nxt   = r_unf;
    w_we        = 1'b0;
    w_waddr     = r_level[IW-1:0];
    if (bus.CLR) begin
      w_level_nxt = LW'(0);
    end else if (bus.PUSH && bus.POP) begin
      if (!w_empty) begin
        // Replace the top entry in place; depth is unchanged.
        w_we    = 1'b1;
        w_waddr = w_level_dec[IW-1:0];
      end else begin
        // Empty stack: the pop half underflows, the push half still lands.
        w_we        = 1'b1;
        w_level_nxt = w_level_inc;
        w_unf_nxt   = 1'b1;
      end
    end else if (bus.PUSH) begin
      if (!w_full) begin
        w_we        = 1'b1;
        w_level_nxt = w_level_inc;
      end else begin
        w_ovf_nxt = 1'b1;
      end
    end else if (bus.POP) begin
      if (!w_empty) begin
        w_level_nxt = w_level_dec;
      end else begin
        w_unf_nxt = 1'b1;
      end
    end else begin
      w_level_nxt = r_level;
    end
  end

  // Stack level and sticky flag registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_level <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_level <= w_level_nxt;
      r_ovf   <= w_ovf_nxt;
      r_unf   <= w_unf_nxt;
    end
  end

  assign bus.TOP   = w_top;
  assign bus.EMPTY = w_empty;
  assign bus.FULL  = w_full;
  assign bus.LEVEL = r_level;
  assign bus.OVF   = r_ovf;
  assign bus.UNF   = r_unf;

endmodule : ret_addr_stack

// File: tb/tb_ret_addr_stack.sv
module tb_ret_addr_stack;

  logic CLK;
  logic RST_N;
  int   n_chk;
  int   n_pass;

  ret_addr_stack_if #(.AW(10), .DEPTH(16)) bus ();

  ret_addr_stack dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [9:0] val);
    bus.PC_COUNT = val;
    bus.PUSH     = 1'b1;
    tick();
    bus.PUSH     = 1'b0;
  endtask

  task automatic pop();
    bus.POP = 1'b1;
    tick();
    bus.POP = 1'b0;
  endtask

  task automatic clr();
    bus.CLR = 1'b1;
    tick();
    bus.CLR = 1'b0;
  endtask

  initial begin
    n_chk          = 0;
    n_pass         = 0;
    RST_N          = 1'b0;
    bus.PC_COUNT   = 10'h000;
    bus.IR_ADDR    = 10'h000;
    bus.PC_MUX_SEL = 2'd0;
    bus.PUSH       = 1'b0;
    bus.POP        = 1'b0;
    bus.CLR        = 1'b0;
    #12;
    RST_N = 1'b1;
    #1;

    // Reset state and source mux
    check("rst_level", 32'(bus.LEVEL), 32'd0);
    check("rst_empty", 32'(bus.EMPTY), 32'd1);
    check("rst_full",  32'(bus.FULL),  32'd0);
    check("rst_top",   32'(bus.TOP),   32'h000);
    check("rst_ovf",   32'(bus.OVF),   32'd0);
    check("rst_unf",   32'(bus.UNF),   32'd0);
    bus.PC_MUX_SEL = 2'd2; #1;
    check("din_intr", 32'(bus.DIN), 32'h3FF);
    bus.PC_MUX_SEL = 2'd0; bus.IR_ADDR = 10'h05A; #1;
    check("din_ir", 32'(bus.DIN), 32'h05A);
    bus.PC_MUX_SEL = 2'd3; #1;
    check("din_rsvd", 32'(bus.DIN), 32'h000);
    bus.PC_MUX_SEL = 2'd1; #1;
    check("din_stack_empty", 32'(bus.DIN), 32'h000);

    // Three pushes, then pop-and-load three times
    push(10'h010); push(10'h020); push(10'h030);
    check("p3_level", 32'(bus.LEVEL), 32'd3);
    check("p3_top",   32'(bus.TOP),   32'h030);
    bus.PC_MUX_SEL = 2'd1;
    bus.POP = 1'b1; #1;
    check("pop1_din", 32'(bus.DIN), 32'h030);
    tick();
    check("pop2_din", 32'(bus.DIN), 32'h020);
    tick();
    check("pop3_din", 32'(bus.DIN), 32'h010);
    tick();
    bus.POP = 1'b0; #1;
    check("pop_empty", 32'(bus.EMPTY), 32'd1);
    check("pop_level", 32'(bus.LEVEL), 32'd0);
    check("pop_unf",   32'(bus.UNF),   32'd0);

    // Fill to DEPTH, then overflow
    for (int i = 0; i < 16; i++) push(10'h100 + 10'(i));
    check("full_full",  32'(bus.FULL),  32'd1);
    check("full_level", 32'(bus.LEVEL), 32'd16);
    check("full_ovf0",  32'(bus.OVF),   32'd0);
    check("full_top",   32'(bus.TOP),   32'h10F);
    push(10'h1FF);
    check("ovf_flag",  32'(bus.OVF),   32'd1);
    check("ovf_level", 32'(bus.LEVEL), 32'd16);
    check("ovf_top",   32'(bus.TOP),   32'h10F);
    pop();
    check("ovf_pop_top",   32'(bus.TOP),   32'h10E);
    check("ovf_pop_level", 32'(bus.LEVEL), 32'd15);
    check("ovf_pop_full",  32'(bus.FULL),  32'd0);
    check("ovf_sticky",    32'(bus.OVF),   32'd1);
    clr();
    check("clr_level",   32'(bus.LEVEL), 32'd0);
    check("clr_ovf_keep", 32'(bus.OVF),  32'd1);

    // Underflow, then push+pop on an empty stack
    pop();
    check("unf_flag",  32'(bus.UNF),   32'd1);
    check("unf_level", 32'(bus.LEVEL), 32'd0);
    bus.PC_COUNT = 10'h077; bus.PUSH = 1'b1; bus.POP = 1'b1;
    tick();
    bus.PUSH = 1'b0; bus.POP = 1'b0;
    check("pp_empty_level", 32'(bus.LEVEL), 32'd1);
    check("pp_empty_top",   32'(bus.TOP),   32'h077);

    // Replace top at LEVEL=2
    clr();
    push(10'h010); push(10'h020);
    check("rep_pre_top", 32'(bus.TOP), 32'h020);
    bus.PC_COUNT = 10'h2AA; bus.PUSH = 1'b1; bus.POP = 1'b1;
    tick();
    bus.PUSH = 1'b0; bus.POP = 1'b0;
    check("rep_level", 32'(bus.LEVEL), 32'd2);
    check("rep_top",   32'(bus.TOP),   32'h2AA);
    pop();
    check("rep_below", 32'(bus.TOP), 32'h010);

    // CLR wins over PUSH
    clr();
    for (int i = 0; i < 5; i++) push(10'h040 + 10'(i));
    check("l5_level", 32'(bus.LEVEL), 32'd5);
    bus.PC_COUNT = 10'h3FE; bus.PUSH = 1'b1; bus.CLR = 1'b1;
    tick();
    bus.PUSH = 1'b0; bus.CLR = 1'b0;
    check("clrpush_level", 32'(bus.LEVEL), 32'd0);
    check("clrpush_empty", 32'(bus.EMPTY), 32'd1);

    // Asynchronous reset between edges
    for (int i = 0; i < 5; i++) push(10'h050 + 10'(i));
    check("ar_pre_level", 32'(bus.LEVEL), 32'd5);
    #2;
    RST_N = 1'b0;
    #1;
    check("ar_level", 32'(bus.LEVEL), 32'd0);
    check("ar_empty", 32'(bus.EMPTY), 32'd1);
    check("ar_ovf",   32'(bus.OVF),   32'd0);
    check("ar_unf",   32'(bus.UNF),   32'd0);
    bus.PUSH = 1'b1;
    tick();
    bus.PUSH = 1'b0;
    check("ar_hold_level", 32'(bus.LEVEL), 32'd0);
    #2;
    RST_N = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_ret_addr_stack
